// File: rtl/mem_types.sv
// mem_types: command and state enums shared by the async-SRAM controller.
package mem_types;
  typedef enum logic [1:0] {SRAM_NOP, SRAM_READ, SRAM_WRITE} sram_cmd_t;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} sram_state_t;
  function automatic logic is_access(input sram_cmd_t c);
    return c == SRAM_READ || c == SRAM_WRITE;
  endfunction
endpackage

// File: rtl/sram_wait_counter.sv
// sram_wait_counter: loadable down-counter with zero flag, times the strobe phase.
module sram_wait_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_dec,
  output logic             o_zero
);
  logic [WIDTH-1:0] r_cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_cnt <= '0;
    else if (i_load) r_cnt <= i_value;
    else if (i_dec && !o_zero) r_cnt <= r_cnt - 1'b1;
  assign o_zero = r_cnt == '0;
endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: req/ready front end driving an async SRAM with registered
// active-low strobes, programmable strobe wait states and back-to-back issue.
module sram_ctrl
  import mem_types::*;
#(
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  sram_cmd_t         req_cmd,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic              sram_not_ce,
  output logic              sram_not_oe,
  output logic              sram_not_we
);
  localparam int CW = $clog2(WAIT_STATES + 2);
  sram_state_t       r_state, w_state_nxt;
  sram_cmd_t         r_cmd, w_cmd_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic              r_ce_n, r_oe_n, r_we_n, r_drive, r_rsp_valid;
  logic              w_accept, w_access, w_zero, w_load;
  logic              w_rd, w_wr, w_ce_n, w_oe_n, w_we_n, w_drive;
  assign req_ready = r_state == IDLE || r_state == DONE;
  assign w_accept  = req_valid && req_ready;
  sram_wait_counter #(.WIDTH(CW)) u_wait (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_value(CW'(WAIT_STATES)),
    .i_dec  (r_state == STROBE),
    .o_zero (w_zero)
  );
  // Pin values are decoded from the next state so they leave straight from flops.
  always_comb begin
    w_access    = w_accept && is_access(req_cmd);
    w_cmd_nxt   = w_accept ? (w_access ? req_cmd : SRAM_NOP) : r_cmd;
    w_state_nxt = w_accept ? (w_access ? SETUP : DONE) :
                  r_state == SETUP  ? STROBE :
                  r_state == STROBE ? (w_zero ? DONE : STROBE) : IDLE;
    w_load      = w_state_nxt == STROBE && r_state != STROBE;
    w_rd        = w_cmd_nxt == SRAM_READ;
    w_wr        = w_cmd_nxt == SRAM_WRITE;
    w_ce_n      = !((w_rd || w_wr) && w_state_nxt != IDLE);
    w_oe_n      = !(w_rd && (w_state_nxt == SETUP || w_state_nxt == STROBE));
    w_we_n      = !(w_wr && w_state_nxt == STROBE);
    w_drive     = w_wr && w_state_nxt != IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state     <= IDLE;
      r_cmd       <= SRAM_NOP;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_drive     <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd       <= w_cmd_nxt;
      r_ce_n      <= w_ce_n;
      r_oe_n      <= w_oe_n;
      r_we_n      <= w_we_n;
      r_drive     <= w_drive;
      r_rsp_valid <= w_state_nxt == DONE;
      if (w_access) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (r_state == STROBE && w_zero && r_cmd == SRAM_READ) r_rdata <= sram_data;
    end
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rdata;
  assign sram_addr   = r_addr;
  assign sram_not_ce = r_ce_n;
  assign sram_not_oe = r_oe_n;
  assign sram_not_we = r_we_n;
  assign sram_data   = r_drive ? r_wdata : {DATA_W{1'bz}};
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: three controller builds (wait states 0/1/3) against a
// transaction-level expectation model, an async SRAM model and a bus keeper.
module tb_sram_ctrl;
  import mem_types::*;
  logic clk;
  int   n_pass, n_tot;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input int g, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL g%0d %s: got %0h expected %0h", g, nm, act, exp);
  endtask
  for (genvar g = 0; g < 3; g++) begin : g_i
    localparam int G   = g;
    localparam int WS  = g == 0 ? 0 : g == 1 ? 1 : 3;
    localparam int DW  = g == 1 ? 8 : 16;
    localparam int LAT = g == 0 ? 3 : g == 1 ? 4 : 6;
    localparam int SW  = g == 0 ? 1 : g == 1 ? 2 : 4;
    localparam logic [DW-1:0] KP = DW'(16'h5A3C);
    localparam logic [DW-1:0] W1 = DW == 8 ? DW'(8'hBC) : DW'(16'hC3A5);
    localparam logic [DW-1:0] W2 = DW'(16'hBEEF);
    logic rst_n, req_valid, req_ready, rsp_valid, ce_n, oe_n, we_n, kp_en;
    sram_cmd_t req_cmd;
    logic [18:0] req_addr, sram_addr, tx_a, a_last, o_addr;
    logic [DW-1:0] req_wdata, rsp_rdata, tx_d, e_rdata, o_rdata;
    wire  [DW-1:0] bus;
    logic [DW-1:0] smem [16];
    logic [DW-1:0] mem_m [16];
    logic [15:0] wr_f = '0;
    bit tx_on, tx_nop, tx_rd, tx_wr, seen, done;
    int cyc, t_acc, n_oe, n_we, n_ce, o_lat;
    function automatic logic [DW-1:0] init_v(input logic [3:0] i);
      return DW'(32'h99 + 32'(i));
    endfunction
    sram_ctrl #(.ADDR_W(19), .DATA_W(DW), .WAIT_STATES(WS)) u_dut (
      .clk(clk), .reset(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_cmd(req_cmd), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .sram_addr(sram_addr),
      .sram_data(bus), .sram_not_ce(ce_n), .sram_not_oe(oe_n), .sram_not_we(we_n)
    );
    assign bus = kp_en ? KP : 'z;
    assign bus = (!ce_n && !oe_n && we_n) ?
                 (wr_f[sram_addr[3:0]] ? smem[sram_addr[3:0]] : init_v(sram_addr[3:0])) : 'z;
    always @(posedge we_n)
      if (!ce_n && rst_n) begin
        smem[sram_addr[3:0]] <= bus;
        wr_f[sram_addr[3:0]] <= 1'b1;
      end
    // One cycle: compare pins against the transaction model, then drive the next request.
    task automatic step(input bit v, input sram_cmd_t cmd, input logic [18:0] a,
                        input logic [DW-1:0] d, output bit acc);
      int k, L;
      bit in_tx, e_rdy, e_oe, e_drv, e_we;
      L = tx_nop ? 1 : WS + 3;
      k = cyc - t_acc;
      in_tx = tx_on && k >= 1 && k <= L;
      e_rdy = !in_tx || k == L;
      e_oe  = in_tx && tx_rd && k <= WS + 2;
      e_we  = in_tx && tx_wr && k >= 2 && k <= WS + 2;
      e_drv = in_tx && tx_wr;
      if (in_tx && k == L && tx_rd) e_rdata = mem_m[tx_a[3:0]];
      kp_en = !e_drv && !e_oe;
      #1;
      chk(G, "ready", 32'(req_ready), 32'(e_rdy));
      chk(G, "rsp_valid", 32'(rsp_valid), 32'(in_tx && k == L));
      chk(G, "rsp_rdata", 32'(rsp_rdata), 32'(e_rdata));
      chk(G, "sram_addr", 32'(sram_addr), 32'(a_last));
      chk(G, "not_ce", 32'(ce_n), 32'(!(in_tx && !tx_nop)));
      chk(G, "not_oe", 32'(oe_n), 32'(!e_oe));
      chk(G, "not_we", 32'(we_n), 32'(!e_we));
      chk(G, "bus", 32'(bus), 32'(e_drv ? tx_d : e_oe ? mem_m[tx_a[3:0]] : KP));
      if (in_tx && k == L && tx_wr) mem_m[tx_a[3:0]] = tx_d;
      if (!oe_n) n_oe++;
      if (!we_n) n_we++;
      if (!ce_n) n_ce++;
      if (rsp_valid) begin
        seen = 1; o_rdata = rsp_rdata; o_addr = sram_addr; o_lat = cyc - t_acc;
      end
      req_valid = v; req_cmd = cmd; req_addr = a; req_wdata = d;
      acc = v && e_rdy;
      if (acc) begin
        tx_on = 1; t_acc = cyc;
        tx_rd = cmd == SRAM_READ; tx_wr = cmd == SRAM_WRITE; tx_nop = !(tx_rd || tx_wr);
        if (!tx_nop) begin tx_a = a; tx_d = d; a_last = a; end
      end
      @(negedge clk);
      cyc++;
    endtask
    task automatic op(input sram_cmd_t cmd, input logic [18:0] a, input logic [DW-1:0] d);
      bit acc;
      n_oe = 0; n_we = 0; n_ce = 0; seen = 0;
      step(1, cmd, a, d, acc);
      for (int i = 0; i < 20 && !seen; i++) step(0, SRAM_NOP, a, d, acc);
      if (!seen) chk(G, "rsp_timeout", 32'(seen), 32'd1);
    endtask
    task automatic reset_check(input string nm);
      chk(G, {nm, "_ready"}, 32'(req_ready), 32'd1);
      chk(G, {nm, "_rsp"}, 32'(rsp_valid), 32'd0);
      chk(G, {nm, "_rdata"}, 32'(rsp_rdata), 32'd0);
      chk(G, {nm, "_addr"}, 32'(sram_addr), 32'd0);
      chk(G, {nm, "_strobes"}, 32'({ce_n, oe_n, we_n}), 32'd7);
      chk(G, {nm, "_bus"}, 32'(bus), 32'(KP));
    endtask
    initial begin
      bit acc, pv;
      int n, r;
      sram_cmd_t pc;
      logic [18:0] pa;
      logic [DW-1:0] pd;
      done = 0; rst_n = 0; kp_en = 1; req_valid = 0; req_cmd = SRAM_NOP;
      req_addr = '0; req_wdata = '0;
      for (int i = 0; i < 16; i++) mem_m[i] = init_v(4'(i));
      tx_on = 0; tx_nop = 0; tx_rd = 0; tx_wr = 0; a_last = '0; e_rdata = '0;
      tx_a = '0; tx_d = '0; cyc = 0; t_acc = 0;
      repeat (2) @(negedge clk);
      #1;
      reset_check("por");
      @(negedge clk);
      rst_n = 1;
      op(SRAM_READ, 19'h00098, '0);
      chk(G, "rd_lit_data", 32'(o_rdata), 32'h00A1);
      chk(G, "rd_lit_lat", 32'(o_lat), 32'(LAT));
      chk(G, "rd_lit_oe_cycles", 32'(n_oe), 32'(SW + 1));
      chk(G, "rd_lit_we_cycles", 32'(n_we), 32'd0);
      chk(G, "rd_lit_ce_cycles", 32'(n_ce), 32'(LAT));
      op(SRAM_WRITE, 19'h00098, W1);
      chk(G, "wr_lit_we_cycles", 32'(n_we), 32'(SW));
      chk(G, "wr_lit_oe_cycles", 32'(n_oe), 32'd0);
      chk(G, "wr_lit_lat", 32'(o_lat), 32'(LAT));
      op(SRAM_WRITE, 19'h7FFFF, W2);
      chk(G, "max_addr_pins", 32'(o_addr), 32'h7FFFF);
      op(SRAM_READ, 19'h7FFFF, '0);
      chk(G, "max_rdata", 32'(o_rdata), DW == 8 ? 32'hEF : 32'hBEEF);
      op(SRAM_READ, 19'h00098, '0);
      chk(G, "readback_w1", 32'(o_rdata), DW == 8 ? 32'hBC : 32'hC3A5);
      step(1, SRAM_WRITE, 19'h00123, DW'(16'h5A96), acc);
      n = 0; acc = 0;
      while (!acc && n < 20) begin step(1, SRAM_READ, 19'h00098, '0, acc); n++; end
      chk(G, "b2b_gap", 32'(n), 32'(LAT));
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) step(0, SRAM_NOP, '0, '0, acc);
      chk(G, "b2b_rdata", 32'(o_rdata), DW == 8 ? 32'hBC : 32'hC3A5);
      op(SRAM_NOP, 19'h00055, '0);
      chk(G, "nop_lat", 32'(o_lat), 32'd1);
      chk(G, "nop_ce_cycles", 32'(n_ce), 32'd0);
      pv = 0; pc = SRAM_NOP; pa = '0; pd = '0;
      for (int i = 0; i < 400; i++) begin
        if (!pv) begin
          pv = $urandom_range(0, 3) != 0;
          r  = $urandom_range(0, 9);
          pc = r == 0 ? SRAM_NOP : r < 5 ? SRAM_READ : SRAM_WRITE;
          pa = 19'($urandom);
          pd = DW'($urandom);
        end
        step(pv, pc, pa, pd, acc);
        if (acc) pv = 0;
      end
      repeat (10) step(0, SRAM_NOP, '0, '0, acc);
      step(1, SRAM_WRITE, 19'h00042, mem_m[2], acc);
      step(0, SRAM_NOP, '0, '0, acc);
      rst_n = 0; kp_en = 1;
      #1;
      reset_check("mid_strobe");
      tx_on = 0; a_last = '0; e_rdata = '0;
      @(negedge clk);
      cyc++;
      rst_n = 1;
      op(SRAM_READ, 19'h00098, '0);
      chk(G, "post_reset_rdata", 32'(o_rdata), 32'(mem_m[8]));
      done = 1;
    end
  end
  initial begin
    bit all_done;
    all_done = 0;
    for (int i = 0; i < 30000 && !all_done; i++) begin
      @(posedge clk);
      all_done = g_i[0].done && g_i[1].done && g_i[2].done;
    end
    if (!all_done) begin
      n_tot++;
      $display("FAIL run_timeout: got %0d%0d%0d done flags expected 111",
               g_i[0].done, g_i[1].done, g_i[2].done);
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
